vc_test_rand_delay_sink: RTL

- Test-harness sink placed directly downstream of a val/rdy test source or a DUT output port.
- Accepts messages under pseudo-random backpressure and compares each one against an expected-message memory.
- Counts mismatches, records the index of the first mismatch, and raises done once the configured message count has been received.
- The bench loads expected messages through a load port, so the block is usable in both RTL and gate-level runs.

---
 rtl/vc_test_rand_delay_sink.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vc_test_rand_delay_sink.sv
// ---------------------------------------------------------------------------
// vc_test_rand_delay_sink
//
// Test-harness sink that sits downstream of a val/rdy source or a DUT output
// port. It accepts messages under pseudo-random backpressure, compares each
// accepted message against a preloaded expected-message memory, and reports
// how the run went.
//
// Ports:
//   clk        clock
//   reset      asynchronous reset, active low (0 = reset asserted)
//   val        upstream message valid
//   rdy        sink ready (combinational from the stall counter)
//   msg        upstream message, p_msg_nbits wide
//   load_en    write one expected message (only while IDLE)
//   load_addr  expected-memory write index
//   load_data  expected-memory write data
//   cfg_nmsgs  number of messages in a run, sampled when start is taken
//   start      begin a run (taken in IDLE or DONE)
//   done       every configured message has been accepted
//   err_flag   at least one mismatch in the current run
//   err_index  index of the first mismatch in the current run
//   err_count  saturating count of mismatches in the current run
// ---------------------------------------------------------------------------
module vc_test_rand_delay_sink #(
    parameter int          p_msg_nbits = 1,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_lfsr_seed = 16'hACE1,
    localparam int         c_index_nbits = $clog2(p_num_msgs)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     val,
    output logic                     rdy,
    input  logic [p_msg_nbits-1:0]   msg,
    input  logic                     load_en,
    input  logic [c_index_nbits-1:0] load_addr,
    input  logic [p_msg_nbits-1:0]   load_data,
    input  logic [c_index_nbits:0]   cfg_nmsgs,
    input  logic                     start,
    output logic                     done,
    output logic                     err_flag,
    output logic [c_index_nbits-1:0] err_index,
    output logic [15:0]              err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [c_index_nbits:0] c_num_msgs = (c_index_nbits + 1)'(p_num_msgs);

    state_t                   state;
    logic [c_index_nbits:0]   nmsgs;
    logic [c_index_nbits:0]   index;
    logic [7:0]               delay_cnt;
    logic [15:0]              lfsr;
    logic [7:0]               delay_draw;
    logic                     go;
    logic                     mismatch;
    logic                     last_msg;
    logic                     start_take;

    logic [p_msg_nbits-1:0]   mem [p_num_msgs];

    // Handshake and status decode. rdy follows the stall counter directly so
    // a zero draw lets the very next cycle accept.
    assign rdy        = (state == RUN) && (delay_cnt == 8'd0);
    assign done       = (state == DONE);
    assign go         = val && rdy;
    assign start_take = start && ((state == IDLE) || (state == DONE));
    assign last_msg   = (index == (nmsgs - 1'b1));

    // Four-state compare so that an x/z bit on msg is reported as a mismatch
    // rather than silently matching.
    assign mismatch   = (msg !== mem[index[c_index_nbits-1:0]]);

    // Stall draw from the low LFSR byte. The full-range case skips the modulo
    // because 256 does not fit the 8-bit divisor.
    generate
        if (p_max_delay >= 255) begin : g_draw_full
            assign delay_draw = lfsr[7:0];
        end else begin : g_draw_mod
            assign delay_draw = lfsr[7:0] % 8'(p_max_delay + 1);
        end
    endgenerate

    // Free-running 16-bit Galois LFSR, shifting right with tap mask B400. It
    // advances every cycle out of reset, independent of the state, so the
    // stall pattern depends only on the cycle at which each draw happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= p_lfsr_seed;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Expected-message memory. It has no reset so that a mid-run reset keeps
    // the loaded vectors, and it only accepts writes while idle.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Run control: start sampling, per-message compare, stall countdown and
    // the error bookkeeping. The error outputs hold once the run is DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nmsgs     <= '0;
            index     <= '0;
            delay_cnt <= 8'd0;
            err_flag  <= 1'b0;
            err_index <= '0;
            err_count <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        nmsgs     <= cfg_nmsgs;
                        index     <= '0;
                        err_flag  <= 1'b0;
                        err_index <= '0;
                        err_count <= 16'd0;
                        delay_cnt <= delay_draw;
                        state     <= (cfg_nmsgs == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (go) begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            if (!err_flag) begin
                                err_flag  <= 1'b1;
                                err_index <= index[c_index_nbits-1:0];
                            end
                        end
                        index     <= index + 1'b1;
                        delay_cnt <= delay_draw;
                        if (last_msg) begin
                            state <= DONE;
                        end
                    end else if (delay_cnt != 8'd0) begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A run longer than the expected memory would compare against stale or
    // aliased entries, so flag it loudly in simulation.
    always @(posedge clk) begin
        if (reset && start_take) begin
            assert (cfg_nmsgs <= c_num_msgs)
                else $error("vc_test_rand_delay_sink: cfg_nmsgs %0d exceeds p_num_msgs %0d",
                            cfg_nmsgs, p_num_msgs);
        end
    end

endmodule
